// File: rtl/rv32_bus_arbiter_pkg.sv
// Shared types and bus widths for the rv32 instruction/data bus arbiter.
package rv32_bus_pkg;

   localparam int BUS_ADDR_WIDTH = 32;
   localparam int BUS_DATA_WIDTH = 32;
   localparam int BUS_MASK_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      HOLD_INSTR = 2'd1,
      HOLD_DATA  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rv32_bus_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment) and an at_limit flag.
module rv32_sat_counter #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             at_limit
);

   localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

   // counter register, holds at LIMIT once reached
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= {WIDTH{1'b0}};
      end else if (clear) begin
         count <= {WIDTH{1'b0}};
      end else if (inc && (count != LIMIT_V)) begin
         count <= count + ONE_V;
      end else begin
         count <= count;
      end
   end

   assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Arbitrates one 32-bit bus between the fetch port and the data port; data has priority
// with starvation protection for fetch. Optional transfer timeout: RV32_BUS_ARB_TIMEOUT_EN.
module rv32_bus_arbiter
   import rv32_bus_pkg::*;
#(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [BUS_ADDR_WIDTH-1:0] instr_address_in,
   input  logic                      instr_read_in,
   output logic [BUS_DATA_WIDTH-1:0] instr_read_value_out,
   output logic                      instr_ready_out,
   output logic                      instr_fault_out,
   input  logic [BUS_ADDR_WIDTH-1:0] data_address_in,
   input  logic                      data_read_in,
   input  logic                      data_write_in,
   input  logic [BUS_MASK_WIDTH-1:0] data_write_mask_in,
   input  logic [BUS_DATA_WIDTH-1:0] data_write_value_in,
   output logic [BUS_DATA_WIDTH-1:0] data_read_value_out,
   output logic                      data_ready_out,
   output logic                      data_fault_out,
   output logic [BUS_ADDR_WIDTH-1:0] bus_address_out,
   output logic                      bus_read_out,
   output logic                      bus_write_out,
   output logic [BUS_MASK_WIDTH-1:0] bus_write_mask_out,
   output logic [BUS_DATA_WIDTH-1:0] bus_write_value_out,
   input  logic [BUS_DATA_WIDTH-1:0] bus_read_value_in,
   input  logic                      bus_ready_in
);

   arb_state_t state_r;
   logic       instr_req_s, data_req_s, pick_data_s;
   logic       grant_instr_s, grant_data_s;
   logic       instr_done_s, data_done_s;
   logic       starve_at_limit_s, timeout_hit_s;
   logic [3:0] starve_count_s;

   // request decode and grant selection; reset suppresses every grant
   always_comb begin
      instr_req_s   = instr_read_in;
      data_req_s    = data_read_in | data_write_in;
      pick_data_s   = data_req_s & ~(instr_req_s & starve_at_limit_s);
      grant_instr_s = 1'b0;
      grant_data_s  = 1'b0;
      if (reset) begin
         grant_instr_s = 1'b0;
         grant_data_s  = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               grant_data_s  = pick_data_s;
               grant_instr_s = ~pick_data_s & instr_req_s;
            end
            HOLD_INSTR: grant_instr_s = 1'b1;
            HOLD_DATA:  grant_data_s  = 1'b1;
            default: begin
               grant_instr_s = 1'b0;
               grant_data_s  = 1'b0;
            end
         endcase
      end
   end

   assign instr_done_s = grant_instr_s & bus_ready_in;
   assign data_done_s  = grant_data_s & bus_ready_in;

   // bus drive and ready/fault routing; an abort drops the strobes for its cycle
   always_comb begin
      bus_address_out      = grant_instr_s ? instr_address_in : data_address_in;
      bus_write_mask_out   = data_write_mask_in;
      bus_write_value_out  = data_write_value_in;
      bus_read_out         = (grant_instr_s | (grant_data_s & data_read_in)) & ~timeout_hit_s;
      bus_write_out        = grant_data_s & data_write_in & ~timeout_hit_s;
      instr_ready_out      = grant_instr_s & (bus_ready_in | timeout_hit_s);
      data_ready_out       = grant_data_s & (bus_ready_in | timeout_hit_s);
      instr_fault_out      = grant_instr_s & timeout_hit_s;
      data_fault_out       = grant_data_s & timeout_hit_s;
      if (timeout_hit_s) begin
         instr_read_value_out = {BUS_DATA_WIDTH{1'b0}};
         data_read_value_out  = {BUS_DATA_WIDTH{1'b0}};
      end else begin
         instr_read_value_out = bus_read_value_in;
         data_read_value_out  = bus_read_value_in;
      end
   end

   // arbiter state: lock the winner until its transfer completes or aborts
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if ((grant_instr_s | grant_data_s) & ~bus_ready_in) begin
                  state_r <= grant_instr_s ? HOLD_INSTR : HOLD_DATA;
               end else begin
                  state_r <= IDLE;
               end
            end
            HOLD_INSTR, HOLD_DATA: begin
               if (bus_ready_in | timeout_hit_s) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   rv32_sat_counter #(.WIDTH(4), .LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .reset    (reset),
      .clear    (instr_done_s | (data_done_s & ~instr_req_s)),
      .inc      (data_done_s & instr_req_s),
      .count    (starve_count_s),
      .at_limit (starve_at_limit_s)
   );

`ifdef RV32_BUS_ARB_TIMEOUT_EN
   logic [7:0] timeout_count_s;
   logic       timeout_at_limit_s;
   logic       timeout_unused_s;

   // counting starts in the granting cycle so hold cycle N sees count N
   rv32_sat_counter #(.WIDTH(8), .LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear    (~((grant_instr_s | grant_data_s) & ~bus_ready_in) | timeout_hit_s),
      .inc      (1'b1),
      .count    (timeout_count_s),
      .at_limit (timeout_at_limit_s)
   );

   assign timeout_hit_s    = (state_r != IDLE) & timeout_at_limit_s & ~bus_ready_in & ~reset;
   assign timeout_unused_s = ^{starve_count_s, timeout_count_s};
`else
   logic timeout_unused_s;

   assign timeout_hit_s    = 1'b0;
   assign timeout_unused_s = ^{starve_count_s, 8'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed self-checking bench for rv32_bus_arbiter (default STARVE_LIMIT=4).
module tb_rv32_bus_arbiter;
   import rv32_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_address_in, data_address_in, data_write_value_in, bus_read_value_in;
   logic        instr_read_in, data_read_in, data_write_in, bus_ready_in;
   logic [3:0]  data_write_mask_in, bus_write_mask_out;
   logic [31:0] instr_read_value_out, data_read_value_out, bus_address_out, bus_write_value_out;
   logic        instr_ready_out, instr_fault_out, data_ready_out, data_fault_out;
   logic        bus_read_out, bus_write_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rv32_bus_arbiter dut (
      .clk                  (clk),
      .reset                (reset),
      .instr_address_in     (instr_address_in),
      .instr_read_in        (instr_read_in),
      .instr_read_value_out (instr_read_value_out),
      .instr_ready_out      (instr_ready_out),
      .instr_fault_out      (instr_fault_out),
      .data_address_in      (data_address_in),
      .data_read_in         (data_read_in),
      .data_write_in        (data_write_in),
      .data_write_mask_in   (data_write_mask_in),
      .data_write_value_in  (data_write_value_in),
      .data_read_value_out  (data_read_value_out),
      .data_ready_out       (data_ready_out),
      .data_fault_out       (data_fault_out),
      .bus_address_out      (bus_address_out),
      .bus_read_out         (bus_read_out),
      .bus_write_out        (bus_write_out),
      .bus_write_mask_out   (bus_write_mask_out),
      .bus_write_value_out  (bus_write_value_out),
      .bus_read_value_in    (bus_read_value_in),
      .bus_ready_in         (bus_ready_in)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ndata;
      int nready;
      int nfault;

      reset = 1'b1; instr_read_in = 1'b1; data_read_in = 1'b1; data_write_in = 1'b0;
      instr_address_in = 32'h0000_1111; data_address_in = 32'h0000_2222;
      data_write_mask_in = 4'h0; data_write_value_in = 32'h0; bus_read_value_in = 32'h0;
      bus_ready_in = 1'b1;
      #1;
      check("rst_bus_read", 32'(bus_read_out), 32'd0);
      check("rst_bus_write", 32'(bus_write_out), 32'd0);
      check("rst_instr_ready", 32'(instr_ready_out), 32'd0);
      check("rst_data_ready", 32'(data_ready_out), 32'd0);
      step();
      check("rst_state", 32'(dut.state_r), 32'(IDLE));

      // single instruction fetch, slave ready in the same cycle
      reset = 1'b0; data_read_in = 1'b0; instr_address_in = 32'h0000_1000;
      bus_read_value_in = 32'h1234_5678;
      #1;
      check("single_bus_read", 32'(bus_read_out), 32'd1);
      check("single_addr", bus_address_out, 32'h0000_1000);
      check("single_instr_ready", 32'(instr_ready_out), 32'd1);
      check("single_data_ready", 32'(data_ready_out), 32'd0);
      check("single_rdata", instr_read_value_out, 32'h1234_5678);
      step();
      check("single_state", 32'(dut.state_r), 32'(IDLE));

      // both request, data wins and is held for three cycles
      instr_address_in = 32'h0000_2000; data_read_in = 1'b1; data_address_in = 32'h0000_3000;
      bus_read_value_in = 32'hCAFE_0001;
      for (int c = 0; c < 3; c++) begin
         bus_ready_in = (c == 2);
         #1;
         check("prio_addr", bus_address_out, 32'h0000_3000);
         check("prio_instr_ready", 32'(instr_ready_out), 32'd0);
         check("prio_data_ready", 32'(data_ready_out), 32'(c == 2));
         step();
      end
      data_read_in = 1'b0; bus_ready_in = 1'b1;
      #1;
      check("prio_instr_next", 32'(instr_ready_out), 32'd1);
      check("prio_instr_addr", bus_address_out, 32'h0000_2000);
      check("prio_data_idle", 32'(data_ready_out), 32'd0);
      step();
      check("prio_starve_clr", 32'(dut.starve_count_s), 32'd0);

      // starvation: four data completions then a forced fetch
      data_read_in = 1'b1; data_address_in = 32'h0000_4000;
      instr_read_in = 1'b1; instr_address_in = 32'h0000_5000;
      ndata = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         ndata += int'(data_ready_out);
         check("starve_instr_wait", 32'(instr_ready_out), 32'd0);
         step();
      end
      check("starve_ndata", 32'(ndata), 32'd4);
      check("starve_count_lim", 32'(dut.starve_count_s), 32'd4);
      #1;
      check("starve_instr_win", 32'(instr_ready_out), 32'd1);
      check("starve_data_lose", 32'(data_ready_out), 32'd0);
      check("starve_instr_addr", bus_address_out, 32'h0000_5000);
      step();
      check("starve_count_clr", 32'(dut.starve_count_s), 32'd0);
      #1;
      check("starve_data_again", 32'(data_ready_out), 32'd1);
      step();

      // store path
      instr_read_in = 1'b0; data_read_in = 1'b0; data_write_in = 1'b1;
      data_write_mask_in = 4'b0110; data_write_value_in = 32'hDEAD_BEEF;
      data_address_in = 32'h8000_0004;
      #1;
      check("store_write", 32'(bus_write_out), 32'd1);
      check("store_read", 32'(bus_read_out), 32'd0);
      check("store_mask", 32'(bus_write_mask_out), 32'h6);
      check("store_value", bus_write_value_out, 32'hDEAD_BEEF);
      check("store_addr", bus_address_out, 32'h8000_0004);
      check("store_ready", 32'(data_ready_out), 32'd1);
      step();

      // idle bus reflects the data port with strobes low
      data_write_in = 1'b0; data_address_in = 32'h0000_0ABC; data_write_mask_in = 4'b1001;
      #1;
      check("idle_read", 32'(bus_read_out), 32'd0);
      check("idle_write", 32'(bus_write_out), 32'd0);
      check("idle_addr", bus_address_out, 32'h0000_0ABC);
      check("idle_mask", 32'(bus_write_mask_out), 32'h9);
      check("idle_ready", 32'(data_ready_out), 32'd0);
      step();

      // reset in the second held data cycle abandons the transfer
      data_read_in = 1'b1; data_address_in = 32'h0000_6000; bus_ready_in = 1'b0;
      step();
      check("hold_state", 32'(dut.state_r), 32'(HOLD_DATA));
      step();
      reset = 1'b1; bus_ready_in = 1'b1;
      #1;
      check("midrst_ready", 32'(data_ready_out), 32'd0);
      check("midrst_read", 32'(bus_read_out), 32'd0);
      step();
      check("midrst_state", 32'(dut.state_r), 32'(IDLE));
      reset = 1'b0; data_read_in = 1'b0;
      #1;
      check("postrst_ready", 32'(data_ready_out), 32'd0);
      step();
      check("postrst_state", 32'(dut.state_r), 32'(IDLE));

      // hung slave
      data_read_in = 1'b1; data_address_in = 32'h0000_7000; bus_ready_in = 1'b0;
      bus_read_value_in = 32'h5555_AAAA;
      nready = 0; nfault = 0;
      for (int c = 0; c < 300; c++) begin
         #1;
         nready += int'(data_ready_out);
         nfault += int'(data_fault_out);
         step();
      end
`ifdef RV32_BUS_ARB_TIMEOUT_EN
      check("hung_nready", 32'(nready), 32'd1);
      check("hung_nfault", 32'(nfault), 32'd1);
`else
      check("hung_nready", 32'(nready), 32'd0);
      check("hung_nfault", 32'(nfault), 32'd0);
      #1;
      check("hung_still_read", 32'(bus_read_out), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
